// File: rtl/irq_ack_ctrl_pkg.sv
// Shared types and defaults for the button-bus interrupt responder.
// Holds the FSM encoding, the vector address type and the vector helper.
package irq_ack_ctrl_pkg;

    typedef logic [7:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        LATCH,
        TAKE,
        SERVICE
    } irq_state_t;

    localparam int          NUM_IRQ_DEF     = 4;
    localparam int          SYNC_STAGES_DEF = 2;
    localparam int          ACK_CYCLES_DEF  = 1;
    localparam int unsigned VEC_BASE_DEF    = 32'h08;
    localparam int unsigned VEC_STRIDE_DEF  = 2;
    localparam bit          IME_RESET_DEF   = 1'b0;

    // Vector table wraps silently when base + idx*stride exceeds addr_t.
    function automatic addr_t vec_of(input int unsigned idx, base, stride);
        return addr_t'(base + idx * stride);
    endfunction

endpackage

// File: rtl/irq_ack_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder for the chain grant lines.
// Source 0 has the highest priority; valid is low when no grant is set.
module irq_prio_enc #(
    parameter int NUM_IRQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ack_ctrl.sv
// CPU-side interrupt responder: synchronises irq, runs the ack handshake,
// encodes the granted source into a vector and tracks the in-service state.
module irq_ack_ctrl
    import irq_ack_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ     = NUM_IRQ_DEF,
    parameter int          SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int          ACK_CYCLES  = ACK_CYCLES_DEF,
    parameter int unsigned VEC_BASE    = VEC_BASE_DEF,
    parameter int unsigned VEC_STRIDE  = VEC_STRIDE_DEF,
    parameter bit          IME_RESET   = IME_RESET_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               irq,
    input  logic [NUM_IRQ-1:0] ie,
    output logic               ack,
    input  logic               boundary,
    input  logic               ei_set,
    input  logic               ei_clr,
    input  logic               reti,
    output logic               int_take,
    output addr_t              vec_addr,
    output logic               in_service,
    output logic               ime,
    output logic [3:0]         spurious_cnt
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int CNT_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;

    irq_state_t             state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   irq_s;
    logic [CNT_W-1:0]       ack_cnt, ack_cnt_n;
    logic                   ime_q, ime_n;
    logic                   svc_q, svc_n;
    logic [3:0]             spur_q, spur_n;
    addr_t                  vec_q, vec_n;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req   (ie),
        .idx   (grant_idx),
        .valid (grant_valid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
        end
    end

    assign irq_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ack_cnt <= '0;
            ime_q   <= IME_RESET;
            svc_q   <= 1'b0;
            spur_q  <= 4'd0;
            vec_q   <= '0;
        end else begin
            state   <= state_n;
            ack_cnt <= ack_cnt_n;
            ime_q   <= ime_n;
            svc_q   <= svc_n;
            spur_q  <= spur_n;
            vec_q   <= vec_n;
        end
    end

    // The grant lines are only meaningful in LATCH; the vector is captured
    // there so it is already stable when int_take is presented.
    always_comb begin
        state_n   = state;
        ack_cnt_n = '0;
        svc_n     = svc_q;
        spur_n    = spur_q;
        vec_n     = vec_q;
        ack       = 1'b0;
        int_take  = 1'b0;

        case (state)
            IDLE: begin
                if (irq_s && ime_q && boundary) begin
                    state_n = ACK;
                end
            end
            ACK: begin
                ack = 1'b1;
                if (ack_cnt == CNT_W'(ACK_CYCLES - 1)) begin
                    state_n = LATCH;
                end else begin
                    ack_cnt_n = ack_cnt + CNT_W'(1);
                end
            end
            LATCH: begin
                if (grant_valid) begin
                    vec_n   = vec_of(32'(grant_idx), VEC_BASE, VEC_STRIDE);
                    state_n = TAKE;
                end else begin
                    if (spur_q != 4'hF) begin
                        spur_n = spur_q + 4'd1;
                    end
                    state_n = IDLE;
                end
            end
            TAKE: begin
                int_take = 1'b1;
                svc_n    = 1'b1;
                state_n  = SERVICE;
            end
            SERVICE: begin
                if (reti) begin
                    svc_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Entering a handler masks interrupts regardless of a concurrent EI;
    // DI beats EI, and RETI re-enables only from inside a handler.
    always_comb begin
        ime_n = ime_q;
        if (state == TAKE) begin
            ime_n = 1'b0;
        end else if (ei_clr) begin
            ime_n = 1'b0;
        end else if (ei_set || (state == SERVICE && reti)) begin
            ime_n = 1'b1;
        end
    end

    assign vec_addr     = vec_q;
    assign in_service   = svc_q;
    assign ime          = ime_q;
    assign spurious_cnt = spur_q;

endmodule

// File: doc/irq_ack_ctrl.md
Name: irq_ack_ctrl

Overview:
- CPU-side responder for the daisy-chained button interrupt bus.
- Samples the wired-OR `irq` line, waits for an instruction boundary with interrupts enabled, and drives the `ack` handshake.
- Reads back the per-device `ie` grant lines, priority-encodes the winner, and hands the CPU a vector address plus a one-cycle take strobe.
- Holds the in-service state until the CPU reports return-from-interrupt.

Parameters:
- NUM_IRQ, 4: number of daisy-chained sources; width of `ie`.
- SYNC_STAGES, 2: flop stages on the asynchronous `irq` input; minimum 2.
- ACK_CYCLES, 1: cycles `ack` is held high; minimum 1.
- VEC_BASE, 'h08: vector address of source 0.
- VEC_STRIDE, 2: address step between consecutive source vectors.
- IME_RESET, 0: master interrupt enable value after reset.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq  in  1  wired-OR request from the button chain; asynchronous.
- ie  in  NUM_IRQ  one-hot grant lines from the chain (`ieo`-qualified).
- ack  out  1  acknowledge to all chain devices.
- boundary  in  1  CPU is between instructions this cycle.
- ei_set  in  1  EI instruction executed.
- ei_clr  in  1  DI instruction executed.
- reti  in  1  return-from-interrupt executed.
- int_take  out  1  one-cycle strobe: CPU saves PC and jumps to `vec_addr`.
- vec_addr  out  addr_t  vector address; valid while `int_take` is high and held afterwards.
- in_service  out  1  a handler is active.
- ime  out  1  master interrupt enable.
- spurious_cnt  out  4  saturating count of acknowledges with no grant.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - `ack` 0, `int_take` 0, `vec_addr` 0, `in_service` 0, `spurious_cnt` 0, `ime`=IME_RESET.
  - Sync chain clears to 0; state is IDLE.
- `irq` passes through SYNC_STAGES flops to give `irq_s`.
- States: IDLE, ACK, LATCH, TAKE, SERVICE.
- IDLE:
  - If `irq_s` & `ime` & `boundary`, go to ACK.
  - `ack` rises on the next edge.
- ACK:
  - `ack`=1 for exactly ACK_CYCLES cycles, then go to LATCH.
  - `irq` dropping during ACK does not abort the handshake.
- LATCH:
  - `ack`=0 for one cycle; `ie` is registered at the end of the cycle.
  - Registered `ie` zero: spurious. `spurious_cnt` increments and saturates at 15; return to IDLE; `ime` unchanged.
  - Otherwise the lowest set bit wins (source 0 has highest priority) and the state goes to TAKE.
- TAKE:
  - `int_take`=1 for one cycle.
  - `vec_addr` = VEC_BASE + idx*VEC_STRIDE, truncated to addr_t width (wraps).
  - `ime` cleared; `in_service` set; go to SERVICE.
- SERVICE:
  - `irq` is ignored.
  - On `reti`: `in_service` 0, `ime` 1, go to IDLE. The new `ime` is usable from the following cycle.
- `reti` outside SERVICE is ignored.
- `ime` updates:
  - `ei_clr` and `ei_set` in the same cycle: `ei_clr` wins.
  - The clear in TAKE overrides `ei_set`.
  - `ei_set`/`ei_clr` in ACK/LATCH do not abort an acknowledge already started.
- Latency: `ack` rises 1 cycle after the IDLE qualifying cycle; `int_take` rises ACK_CYCLES+1 cycles after `ack` rises.
- Reset asserted mid-sequence: `ack` and `int_take` drop immediately (asynchronous); no partial vector is presented.

Decomposition:
- Shared package (types.svh) holds:
  - `addr_t` (existing)
  - `irq_state_t` enum (IDLE, ACK, LATCH, TAKE, SERVICE)
  - NUM_IRQ constant
  - vector defaults
- One sub-module, `irq_prio_enc`: combinational NUM_IRQ-to-index lowest-bit encoder with a valid flag.

Test Plan:
- `ime`=1, `boundary`=1, `irq` rises, chain grants `ie`=0100 → `ack` high 1 cycle, `int_take` 2 cycles after `ack` rise, `vec_addr`=0x0C, `ime`=0, `in_service`=1.
- `ie`=0110 in LATCH → source 1 wins, `vec_addr`=0x0A.
- Ack with `ie`=0000 → no `int_take`, `spurious_cnt` 0→1, state IDLE, `ime` stays 1; repeat 20 times → `spurious_cnt`=15.
- `irq` held in SERVICE, then `reti` → no `ack` until `reti`; `ack` re-asserts once `ime`=1 and `boundary` are seen.
- `ime`=0 with `irq` high 10 cycles → `ack` stays 0; `ei_set` and `ei_clr` in the same cycle → `ime` stays 0.
- reset=0 during ACK → `ack` drops within the same cycle, `in_service` 0, `spurious_cnt` 0, `ime`=IME_RESET.
